// File: rtl/pipo_route_engine.sv
// Two-operand PIPO load/execute engine: captures A then B under a start/done
// handshake, combines them by mode and decodes B's MSBs into one-hot slave selects.
module pipo_route_engine #(
   parameter int DATA_W   = 16,
   parameter int SEL_W    = 2,
   parameter int NUM_HSEL = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [DATA_W-1:0]   data_in1,
   input  logic [DATA_W-1:0]   data_in2,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   data_out,
   output logic [NUM_HSEL-1:0] hsel,
   output logic                err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_B = 2'd1,
      EXEC   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     reg_a_q, reg_a_d;
   logic [DATA_W-1:0]     reg_b_q, reg_b_d;
   logic [1:0]            mode_q, mode_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DATA_W-1:0]     data_out_q, data_out_d;
   logic [NUM_HSEL-1:0]   hsel_q, hsel_d;
   logic                  err_q, err_d;

   logic [DATA_W-1:0]     result_s;
   logic [SEL_W-1:0]      idx_s;
   logic [NUM_HSEL-1:0]   dec_s;

   // Mode-selected ALU and slave-index decode from the captured operands.
   always_comb begin
      result_s = reg_a_q;
      case (mode_q)
         2'd0:    result_s = reg_a_q;
         2'd1:    result_s = reg_b_q;
         2'd2:    result_s = reg_a_q + reg_b_q;
         2'd3:    result_s = reg_a_q ^ reg_b_q;
         default: result_s = reg_a_q;
      endcase
      idx_s = reg_b_q[DATA_W-1 -: SEL_W];
      dec_s = '0;
      for (int i = 0; i < NUM_HSEL; i++) begin
         dec_s[i] = (idx_s == SEL_W'(i));
      end
   end

   // Next-state and output-register logic; an out-of-range index leaves dec_s all-zero.
   always_comb begin
      state_d    = state_q;
      reg_a_d    = reg_a_q;
      reg_b_d    = reg_b_q;
      mode_d     = mode_q;
      done_d     = 1'b0;
      data_out_d = data_out_q;
      hsel_d     = hsel_q;
      err_d      = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               reg_a_d = data_in1;
               mode_d  = mode;
               state_d = LOAD_B;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD_B: begin
            reg_b_d = data_in2;
            state_d = EXEC;
         end
         EXEC: begin
            data_out_d = result_s;
            hsel_d     = dec_s;
            err_d      = ~|dec_s;
            done_d     = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == LOAD_B) || (state_d == EXEC);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         reg_a_q    <= '0;
         reg_b_q    <= '0;
         mode_q     <= 2'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         data_out_q <= '0;
         hsel_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         reg_a_q    <= reg_a_d;
         reg_b_q    <= reg_b_d;
         mode_q     <= mode_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         data_out_q <= data_out_d;
         hsel_q     <= hsel_d;
         err_q      <= err_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_out_q;
   assign hsel     = hsel_q;
   assign err      = err_q;

endmodule

// File: tb/tb_pipo_route_engine.sv
// Directed bench for pipo_route_engine: expected results are queued when a
// transaction is driven and compared when done is observed.
module tb_pipo_route_engine;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  mode;
   logic [15:0] data_in1;
   logic [15:0] data_in2;
   logic        busy;
   logic        done;
   logic [15:0] data_out;
   logic [2:0]  hsel;
   logic        err;

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  h;
      logic        e;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   pipo_route_engine #(.DATA_W(16), .SEL_W(2), .NUM_HSEL(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .data_in1(data_in1), .data_in2(data_in2), .busy(busy), .done(done),
      .data_out(data_out), .hsel(hsel), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Independent reference: mode ALU plus index decode for NUM_HSEL=3.
   function automatic exp_t model(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b);
      exp_t r;
      logic [1:0] idx;
      case (m)
         2'd0:    r.d = a;
         2'd1:    r.d = b;
         2'd2:    r.d = 16'(a + b);
         default: r.d = a ^ b;
      endcase
      idx = b[15:14];
      if (idx == 2'd3) begin
         r.h = 3'b000;
         r.e = 1'b1;
      end else begin
         r.h = 3'b001 << idx;
         r.e = 1'b0;
      end
      return r;
   endfunction

   task automatic pop_and_compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_data_out"}, {16'd0, data_out}, {16'd0, e.d});
         chk({tag, "_hsel"}, {29'd0, hsel}, {29'd0, e.h});
         chk({tag, "_err"}, {31'd0, err}, {31'd0, e.e});
      end
   endtask

   // One full transaction; called at a negedge while the DUT is idle.
   task automatic run_txn(input string tag, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input exp_t e);
      int n;
      exp_q.push_back(e);
      start = 1'b1; mode = m; data_in1 = a;
      @(negedge clk);
      start = 1'b0; data_in2 = b;
      chk({tag, "_busy_loadb"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, "_busy_exec"}, {31'd0, busy}, 32'd1);
      chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 8);
      chk({tag, "_latency"}, n, 32'd1);
      chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
      pop_and_compare(tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      chk({tag, "_hold"}, {16'd0, data_out}, {16'd0, e.d});
   endtask

   initial begin
      exp_t  e;
      int    n;
      logic [15:0] a;
      rst_n = 1'b0; start = 1'b0; mode = 2'd0; data_in1 = 16'd0; data_in2 = 16'd0;
      #12;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_out", {13'd0, data_out, hsel}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      e = '{d: 16'h0008, h: 3'b010, e: 1'b0};
      run_txn("t1_pass_a", 2'd0, 16'h0008, 16'h4008, e);
      e = '{d: 16'h0000, h: 3'b001, e: 1'b0};
      run_txn("t2_add_wrap", 2'd2, 16'hFFFF, 16'h0001, e);
      e = '{d: 16'hC000, h: 3'b000, e: 1'b1};
      run_txn("t3_idx_oob", 2'd1, 16'h1234, 16'hC000, e);
      e = '{d: 16'h8FF0, h: 3'b100, e: 1'b0};
      run_txn("t4_xor", 2'd3, 16'h00FF, 16'h8F0F, e);
      for (int i = 0; i < 4; i++) begin
         logic [15:0] ra, rb;
         ra = 16'($urandom);
         rb = 16'($urandom);
         run_txn("rnd", 2'(i), ra, rb, model(2'(i), ra, rb));
      end

      // Reset while in LOAD_B aborts without a done pulse.
      start = 1'b1; mode = 2'd2; data_in1 = 16'h1111;
      @(negedge clk);
      start = 1'b0; data_in2 = 16'h4001;
      chk("t5_in_loadb", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_out", {13'd0, data_out, hsel}, 32'd0);
      chk("t5_err_done", {30'd0, err, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("t5_no_done", n, 32'd0);
      e = '{d: 16'h5555, h: 3'b010, e: 1'b0};
      run_txn("t5_after", 2'd2, 16'h1111, 16'h4444, e);

      // start held high: a transaction accepted every third edge.
      start = 1'b1; mode = 2'd2; data_in2 = 16'h8001;
      for (int k = 0; k < 12; k++) begin
         if (k % 3 == 0) begin
            a = 16'(k * 16'h0111);
            data_in1 = a;
            exp_q.push_back(model(2'd2, a, 16'h8001));
         end
         @(negedge clk);
         chk("t6_busy", {31'd0, busy}, (k % 3 == 2) ? 32'd0 : 32'd1);
         chk("t6_done", {31'd0, done}, (k % 3 == 2) ? 32'd1 : 32'd0);
         if (done) pop_and_compare("t6");
      end
      start = 1'b0;
      chk("t6_queue_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
